// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Requester indices; also used directly as the AXI ID of each requester.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // A line is 64 bytes, so the low address bits are dropped.
    localparam int LINE_OFFSET_BITS = 6;

    // Two-way round-robin choice: a lone requester wins, a tie goes to the
    // requester that was not granted last.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        if (req[REQ_I] && req[REQ_D]) begin
            return ~last_grant;
        end else if (req[REQ_D]) begin
            return REQ_D;
        end else begin
            return REQ_I;
        end
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Two-input round-robin arbiter holding the last_grant history bit.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic [1:0] grant,
    output logic       grant_idx
);
    import axi_rd_arb_pkg::*;

    logic last_grant_reg;

    assign grant_idx = rr_pick(req, last_grant_reg);

    // One-hot grant for the current winner, empty when nobody requests.
    always_comb begin
        grant = 2'b00;
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // History starts at D so that I wins the first contest after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= REQ_D;
        end else if (update_en && (|req)) begin
            last_grant_reg <= grant_idx;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between instruction fetch (I) and data load (D).
// One fixed-length INCR line burst is in flight at a time; R beats are passed
// straight through to the owner with no buffering.
module axi_read_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  i_req_ready,
    output logic                  d_req_ready,
    output logic                  i_resp_valid,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  i_resp_last,
    output logic                  d_resp_last,
    output logic                  i_resp_err,
    output logic                  d_resp_err,
    input  logic                  i_resp_ready,
    input  logic                  d_resp_ready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  protocol_err
);
    import axi_rd_arb_pkg::*;

    // One spare bit so a runaway burst saturates instead of wrapping to a
    // value that looks like a legal beat index.
    localparam int                     CNT_W     = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]       LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0]  LINE_MASK = ~ADDR_WIDTH'((1 << LINE_OFFSET_BITS) - 1);

    arb_state_t             state_reg;
    arb_state_t             state_next;
    logic [ADDR_WIDTH-1:0]  araddr_reg;
    logic [ID_WIDTH-1:0]    arid_reg;
    logic                   owner_reg;
    logic [CNT_W-1:0]       beat_cnt_reg;
    logic                   protocol_err_reg;

    logic [1:0]             req;
    logic [1:0]             grant;
    logic                   grant_idx;
    logic                   in_idle;
    logic                   take_req;
    logic                   ar_hs;
    logic                   r_hs;
    logic                   owner_ready;
    logic                   beat_err;

    assign req         = {d_req_valid, i_req_valid};
    assign in_idle     = (state_reg == IDLE);
    assign take_req    = in_idle && (|req);
    assign ar_hs       = (state_reg == ADDR) && m_axi_arready;
    assign owner_ready = (owner_reg == REQ_D) ? d_resp_ready : i_resp_ready;
    assign r_hs        = m_axi_rvalid && m_axi_rready;

    // Any accepted beat that disagrees with the expected count or ID.
    assign beat_err = r_hs && ((m_axi_rlast && (beat_cnt_reg != LAST_BEAT)) ||
                               (!m_axi_rlast && (beat_cnt_reg == LAST_BEAT)) ||
                               (m_axi_rid != arid_reg));

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .update_en (in_idle),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Fixed AR attributes: full-width INCR line burst, normal access.
    assign m_axi_arid    = arid_reg;
    assign m_axi_araddr  = araddr_reg;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = AXI_SIZE_8B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b000;
    assign protocol_err  = protocol_err_reg;

    // State register; an asserted reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: grant -> address phase -> data phase until the rlast beat.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req) state_next = ADDR;
            ADDR:    if (m_axi_arready) state_next = DATA;
            DATA:    if (r_hs && m_axi_rlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: grant pulse in IDLE, arvalid in ADDR, R steering in DATA.
    always_comb begin
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        i_resp_valid  = 1'b0;
        i_resp_data   = '0;
        i_resp_last   = 1'b0;
        i_resp_err    = 1'b0;
        d_resp_valid  = 1'b0;
        d_resp_data   = '0;
        d_resp_last   = 1'b0;
        d_resp_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                // The grant is combinational, so mask it while reset is held.
                i_req_ready = grant[REQ_I] && reset;
                d_req_ready = grant[REQ_D] && reset;
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
            end
            DATA: begin
                m_axi_rready = owner_ready;
                if (owner_reg == REQ_D) begin
                    d_resp_valid = m_axi_rvalid;
                    d_resp_data  = m_axi_rdata;
                    d_resp_last  = m_axi_rlast;
                    d_resp_err   = (m_axi_rresp != 2'b00);
                end else begin
                    i_resp_valid = m_axi_rvalid;
                    i_resp_data  = m_axi_rdata;
                    i_resp_last  = m_axi_rlast;
                    i_resp_err   = (m_axi_rresp != 2'b00);
                end
            end
            default: ;
        endcase
    end

    // Capture the winner's line address and ID at grant; count accepted beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            araddr_reg   <= '0;
            arid_reg     <= '0;
            owner_reg    <= REQ_I;
            beat_cnt_reg <= '0;
        end else begin
            if (take_req) begin
                araddr_reg <= ((grant_idx == REQ_D) ? d_req_addr : i_req_addr) & LINE_MASK;
                arid_reg   <= ID_WIDTH'(grant_idx);
                owner_reg  <= grant_idx;
            end
            if (ar_hs) begin
                beat_cnt_reg <= '0;
            end else if (r_hs && (beat_cnt_reg != '1)) begin
                beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Sticky protocol error; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            protocol_err_reg <= 1'b0;
        end else if (beat_err) begin
            protocol_err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: the bench acts as both requesters and
// the AXI slave, driving inputs on the falling edge and sampling 1 ns later.
module tb_axi_read_arbiter;

    localparam int ID_WIDTH   = 13;
    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 64;
    localparam int BURST_LEN  = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  i_req_valid = 1'b0;
    logic                  d_req_valid = 1'b0;
    logic [ADDR_WIDTH-1:0] i_req_addr = '0;
    logic [ADDR_WIDTH-1:0] d_req_addr = '0;
    logic                  i_req_ready, d_req_ready;
    logic                  i_resp_valid, d_resp_valid;
    logic [DATA_WIDTH-1:0] i_resp_data, d_resp_data;
    logic                  i_resp_last, d_resp_last;
    logic                  i_resp_err, d_resp_err;
    logic                  i_resp_ready = 1'b1;
    logic                  d_resp_ready = 1'b1;
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready = 1'b0;
    logic [ID_WIDTH-1:0]   m_axi_rid = '0;
    logic [DATA_WIDTH-1:0] m_axi_rdata = '0;
    logic [1:0]            m_axi_rresp = 2'b00;
    logic                  m_axi_rlast = 1'b0;
    logic                  m_axi_rvalid = 1'b0;
    logic                  m_axi_rready;
    logic                  protocol_err;

    int    checks = 0;
    int    errors = 0;
    string tname  = "reset";

    always #5 clk = ~clk;

    axi_read_arbiter #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (i_req_valid),
        .d_req_valid   (d_req_valid),
        .i_req_addr    (i_req_addr),
        .d_req_addr    (d_req_addr),
        .i_req_ready   (i_req_ready),
        .d_req_ready   (d_req_ready),
        .i_resp_valid  (i_resp_valid),
        .d_resp_valid  (d_resp_valid),
        .i_resp_data   (i_resp_data),
        .d_resp_data   (d_resp_data),
        .i_resp_last   (i_resp_last),
        .d_resp_last   (d_resp_last),
        .i_resp_err    (i_resp_err),
        .d_resp_err    (d_resp_err),
        .i_resp_ready  (i_resp_ready),
        .d_resp_ready  (d_resp_ready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .protocol_err  (protocol_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tname, tag, obs, exp);
        end
    endtask

    // Runs one burst starting in the grant cycle (called at a falling edge).
    // rlast is sent on beat last_at, rresp=2'b10 on beat err_at, and if
    // abort_at is nonzero reset is asserted when that beat is presented.
    task automatic burst(input logic owner, input logic [63:0] addr_exp, input int ar_wait,
                         input int last_at, input int err_at, input int abort_at,
                         input bit toggle, input bit keep);
        int          beat;
        int          cyc;
        int          delivered;
        logic        rdy;
        logic        own_valid, own_last, own_err, other_valid;
        logic [63:0] own_data;
        logic [63:0] data;
        beat = 1;
        cyc = 0;
        delivered = 0;

        #1;
        check("grant_i", i_req_ready, !owner);
        check("grant_d", d_req_ready, owner);
        check("arvalid_idle", m_axi_arvalid, 1'b0);
        @(negedge clk);
        if (!keep) begin
            if (owner) d_req_valid = 1'b0;
            else       i_req_valid = 1'b0;
        end

        // Address phase, with stray R beats offered while arready is low.
        for (int w = 0; w <= ar_wait; w++) begin
            m_axi_arready = (w == ar_wait);
            m_axi_rvalid  = (w != ar_wait);
            m_axi_rid     = ID_WIDTH'(owner);
            #1;
            check("arvalid", m_axi_arvalid, 1'b1);
            check("araddr", m_axi_araddr, addr_exp);
            check("arid", m_axi_arid, 64'(owner));
            check("rready_addr", m_axi_rready, 1'b0);
            check("resp_valid_addr", i_resp_valid | d_resp_valid, 1'b0);
            check("req_ready_addr", i_req_ready | d_req_ready, 1'b0);
            if (w == 0) begin
                check("arlen", m_axi_arlen, 64'd7);
                check("arsize", m_axi_arsize, 64'd3);
                check("arburst", m_axi_arburst, 64'd1);
            end
            @(negedge clk);
        end
        m_axi_arready = 1'b0;

        // Data phase: the slave model advances only on an accepted beat.
        while (beat <= last_at && cyc < 64) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            if (owner) begin
                d_resp_ready = rdy;
                i_resp_ready = !rdy;
            end else begin
                i_resp_ready = rdy;
                d_resp_ready = !rdy;
            end
            data = 64'hA5A5_0000_0000_0000 | (64'(owner) << 32) | 64'(beat);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = data;
            m_axi_rlast  = (beat == last_at);
            m_axi_rresp  = (beat == err_at) ? 2'b10 : 2'b00;
            m_axi_rid    = ID_WIDTH'(owner);
            if (beat == abort_at) begin
                i_req_valid = 1'b1;
                d_req_valid = 1'b1;
                reset = 1'b0;
                #1;
                check("rst_i_valid", i_resp_valid, 1'b0);
                check("rst_i_data", i_resp_data, 64'd0);
                check("rst_i_last", i_resp_last, 1'b0);
                check("rst_i_err", i_resp_err, 1'b0);
                check("rst_d_valid", d_resp_valid, 1'b0);
                check("rst_req_ready", i_req_ready | d_req_ready, 1'b0);
                check("rst_arvalid", m_axi_arvalid, 1'b0);
                check("rst_rready", m_axi_rready, 1'b0);
                check("rst_perr", protocol_err, 1'b0);
                check("rst_araddr", m_axi_araddr, 64'd0);
                check("rst_arid", m_axi_arid, 64'd0);
                @(posedge clk);
                #1;
                check("rst_hold_req_ready", i_req_ready | d_req_ready, 1'b0);
                check("rst_hold_arvalid", m_axi_arvalid, 1'b0);
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                i_resp_ready = 1'b1;
                d_resp_ready = 1'b1;
                @(negedge clk);
                $display("[%0t] %s: owner=%0d abandoned at beat %0d by reset", $time, tname, owner, beat);
                return;
            end
            #1;
            own_valid   = owner ? d_resp_valid : i_resp_valid;
            own_data    = owner ? d_resp_data  : i_resp_data;
            own_last    = owner ? d_resp_last  : i_resp_last;
            own_err     = owner ? d_resp_err   : i_resp_err;
            other_valid = owner ? i_resp_valid : d_resp_valid;
            check("rready", m_axi_rready, rdy);
            check("resp_valid", own_valid, 1'b1);
            check("resp_data", own_data, data);
            check("resp_last", own_last, beat == last_at);
            check("resp_err", own_err, beat == err_at);
            check("other_valid", other_valid, 1'b0);
            if (own_valid && rdy) delivered++;
            if (m_axi_rready) beat++;
            cyc++;
            @(negedge clk);
        end
        check("no_timeout", cyc < 64, 1'b1);
        check("delivered", 64'(delivered), 64'(last_at));
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        i_resp_ready = 1'b1;
        d_resp_ready = 1'b1;
        $display("[%0t] %s: owner=%0d araddr=0x%0h beats=%0d cycles=%0d",
                 $time, tname, owner, addr_exp, delivered, cyc);
    endtask

    initial begin
        // Reset values, with I already requesting to show the grant is masked.
        i_req_valid = 1'b1;
        i_req_addr  = 64'h0000_0000_8000_0048;
        repeat (2) @(negedge clk);
        #1;
        check("i_req_ready", i_req_ready, 1'b0);
        check("d_req_ready", d_req_ready, 1'b0);
        check("arvalid", m_axi_arvalid, 1'b0);
        check("rready", m_axi_rready, 1'b0);
        check("resp_valid", i_resp_valid | d_resp_valid, 1'b0);
        check("perr", protocol_err, 1'b0);
        check("araddr", m_axi_araddr, 64'd0);
        check("arid", m_axi_arid, 64'd0);
        check("arlen", m_axi_arlen, 64'd7);
        check("arsize", m_axi_arsize, 64'd3);
        check("arburst", m_axi_arburst, 64'd1);
        check("arlock_cache_prot", {m_axi_arlock, m_axi_arcache, m_axi_arprot}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single I request, arready after 2 wait cycles.
        tname = "single_i";
        burst(1'b0, 64'h0000_0000_8000_0040, 2, 8, 0, 0, 1'b0, 1'b0);
        check("idle_arvalid", m_axi_arvalid, 1'b0);
        check("idle_rready", m_axi_rready, 1'b0);
        check("perr", protocol_err, 1'b0);

        // Both requesting from reset: I, D, I.
        tname = "rr_reset";
        reset = 1'b0;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        i_req_addr  = 64'h1000_0000_0000_1234;
        d_req_addr  = 64'h2000_0000_0000_00BF;
        @(negedge clk);
        reset = 1'b1;
        tname = "rr_1_i";
        burst(1'b0, 64'h1000_0000_0000_1200, 0, 8, 0, 0, 1'b0, 1'b1);
        tname = "rr_2_d";
        burst(1'b1, 64'h2000_0000_0000_0080, 1, 8, 0, 0, 1'b0, 1'b1);
        tname = "rr_3_i";
        burst(1'b0, 64'h1000_0000_0000_1200, 0, 8, 0, 0, 1'b0, 1'b0);

        // D still requesting: its burst runs with d_resp_ready toggling.
        tname = "backpressure_d";
        burst(1'b1, 64'h2000_0000_0000_0080, 0, 8, 0, 0, 1'b1, 1'b0);
        check("perr", protocol_err, 1'b0);

        // Early rlast on beat 5 sets the sticky error.
        tname = "early_last";
        i_req_valid = 1'b1;
        i_req_addr  = 64'h0000_0000_3000_0007;
        burst(1'b0, 64'h0000_0000_3000_0000, 0, 5, 0, 0, 1'b0, 1'b0);
        check("perr_set", protocol_err, 1'b1);
        check("idle_arvalid", m_axi_arvalid, 1'b0);
        tname = "after_early";
        i_req_valid = 1'b1;
        i_req_addr  = 64'h0000_0000_4000_0040;
        burst(1'b0, 64'h0000_0000_4000_0040, 1, 8, 0, 0, 1'b0, 1'b0);
        check("perr_sticky", protocol_err, 1'b1);

        // Error response on beat 3, then reset at beat 4.
        tname = "rresp_abort";
        i_req_valid = 1'b1;
        i_req_addr  = 64'h0000_0000_5000_0123;
        burst(1'b0, 64'h0000_0000_5000_0100, 0, 8, 3, 4, 1'b0, 1'b0);
        reset = 1'b1;
        i_req_addr = 64'h0000_0000_7000_0000;
        d_req_addr = 64'h0000_0000_6000_0FC0;
        tname = "post_reset_i";
        burst(1'b0, 64'h0000_0000_7000_0000, 0, 8, 0, 0, 1'b0, 1'b0);
        tname = "post_reset_d";
        burst(1'b1, 64'h0000_0000_6000_0FC0, 0, 8, 0, 0, 1'b0, 1'b0);
        check("perr_cleared", protocol_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the core's single AXI read channel (AR and R) between two requesters: instruction fetch (port I) and data load (port D). Each requester issues a line-fill request. The arbiter grants one requester at a time using round-robin, issues one fixed-length INCR burst, and steers the returned beats back to the winner. Only one burst is in flight at a time. The block sits between the fetch/load units and the top-level `m_axi_ar*`/`m_axi_r*` ports.

## Interface
- `ID_WIDTH`, default 13: width of the AXI ID fields.
- `ADDR_WIDTH`, default 64: width of the byte address.
- `DATA_WIDTH`, default 64: width of each beat.
- `BURST_LEN`, default 8: beats per burst (64-byte line).
- `clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `i_req_valid`, `d_req_valid` in 1: a requester wants a line.
- `i_req_addr`, `d_req_addr` in ADDR_WIDTH: byte address; the low 6 bits are ignored.
- `i_req_ready`, `d_req_ready` out 1: grant pulse; the request is accepted this cycle.
- `i_resp_valid`, `d_resp_valid` out 1: a beat is available for that requester.
- `i_resp_data`, `d_resp_data` out DATA_WIDTH: beat data.
- `i_resp_last`, `d_resp_last` out 1: final beat of the burst.
- `i_resp_err`, `d_resp_err` out 1: `m_axi_rresp` was nonzero on this beat.
- `i_resp_ready`, `d_resp_ready` in 1: the requester can accept a beat.
- `m_axi_arid` out ID_WIDTH, `m_axi_araddr` out ADDR_WIDTH, `m_axi_arlen` out 8, `m_axi_arsize` out 3, `m_axi_arburst` out 2, `m_axi_arlock` out 1, `m_axi_arcache` out 4, `m_axi_arprot` out 3, `m_axi_arvalid` out 1, `m_axi_arready` in 1: AR channel.
- `m_axi_rid` in ID_WIDTH, `m_axi_rdata` in DATA_WIDTH, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1: R channel.
- `protocol_err` out 1: sticky flag; set on an RLAST/beat-count mismatch or an RID mismatch.

## Operation
- There are three states: IDLE, ADDR, DATA. The reset state is IDLE.
- **IDLE:**
  - If any `*_req_valid` is high, the 2-way round-robin picks a winner combinationally.
  - The winner's `*_req_ready` pulses for one cycle.
  - The arbiter registers `araddr = {addr[63:6], 6'b0}`, `arid = index` (I=0, D=1) and `owner`, then moves to ADDR.
- **ADDR:**
  - `m_axi_arvalid=1`. `araddr`/`arid` stay stable until `m_axi_arready`.
  - On the handshake cycle, move to DATA and clear `beat_cnt`.
- **DATA:**
  - `m_axi_rready` = the owner's `*_resp_ready`.
  - The owner's `resp_valid`/`data`/`last` follow `rvalid`/`rdata`/`rlast` combinationally.
  - `resp_err = (rresp != 0)`.
  - The non-owner's `resp_valid` is 0.
  - Each accepted beat (`rvalid && rready`) increments `beat_cnt`.
  - The beat with `rlast` returns the arbiter to IDLE.
- **Fixed AR fields:** `arlen = BURST_LEN-1`, `arsize = 3'b011`, `arburst = 2'b01` (INCR), `arlock = 0`, `arcache = 0`, `arprot = 0`.
- **Round-robin:**
  - `last_grant` resets to D, so I wins the first contest.
  - When both request, the one that is not `last_grant` wins.
  - A lone requester always wins.
- **Error conditions:**
  - `protocol_err` sets if `rlast` arrives with `beat_cnt != BURST_LEN-1`.
  - It also sets if beat BURST_LEN-1 is accepted without `rlast`; the burst then still ends only on `rlast`.
  - It also sets if `rid != arid` on an accepted beat.
  - It clears only on reset.
- **Reset mid-burst:** all state clears immediately and any in-flight burst is abandoned. Requesters must re-request.

## Timing
- Reset values:
  - All `*_req_ready`, `*_resp_*`, `m_axi_arvalid`, `m_axi_rready` and `protocol_err` are 0.
  - `araddr` and `arid` are 0.
  - The fixed AR fields hold their constant values.
- Grant to `arvalid`: 1 cycle. `arvalid` is registered, asserted in the cycle after the grant.
- R to requester: 0 cycles, pass-through. No buffering inside the block.
- After the `rlast` beat:
  - The arbiter is in IDLE the next cycle.
  - A new grant can happen in that same cycle.
  - Minimum occupancy per burst is 1 (IDLE) + 1 (ADDR) + BURST_LEN cycles.
- A request deasserted before its grant is dropped without side effects.
- `*_req_addr` is sampled only in the grant cycle.
- R beats arriving in IDLE or ADDR are not accepted (`rready=0`).

## Structure
- Package `axi_rd_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, ADDR, DATA);
  - the requester indices `REQ_I=0` and `REQ_D=1`;
  - the constants `AXI_SIZE_8B=3'b011` and `AXI_BURST_INCR=2'b01`.
- Sub-module `rr_arbiter2` contains the 2-input round-robin with the `last_grant` register. Its update-enable is driven by the IDLE-state grant.

## Test plan
- **Single I request:** `i_req_addr=0x8000_0048`, arready after 2 cycles, 8 beats with `rvalid` held high.
  - Expect `araddr=0x8000_0040`, `arid=0`, `arlen=7`, `arsize=3`, `arburst=1`.
  - Expect 8 `i_resp_valid` pulses with data matching, `i_resp_last` on beat 8, and `d_resp_valid=0` throughout.
- **I and D both valid from reset, held for 3 bursts:** grants go I, D, I, with `arid` 0, 1, 0.
- **Backpressure:** `d_resp_ready` toggles every other cycle during a D burst.
  - Expect `m_axi_rready` to mirror it, all 8 beats delivered, and no beat lost or duplicated.
- **Early `rlast` on beat 5:** expect the arbiter to return to IDLE, `protocol_err=1` and stay set.
  - The next I request then proceeds normally.
- **`rresp=2'b10` on beat 3, and reset mid-burst:**
  - Expect `resp_err` set only on beat 3.
  - Asserting `reset` low at beat 4 forces all outputs to 0 asynchronously.
  - After release, the first grant goes to I.
